// File: rtl/adapter_ppfifo_wl_2_axi_stream.sv
// Drains Ping Pong FIFO blocks and replays them as an AXI Stream master.
// A 2-entry skid buffer absorbs the PPFIFO read latency and sink back-pressure.
module adapter_ppfifo_wl_2_axi_stream #(
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter bit LAST_ON_BLOCK = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_ppfifo_rdy,
  output logic                    o_ppfifo_act,
  input  logic [23:0]             i_ppfifo_size,
  output logic                    o_ppfifo_stb,
  input  logic [DATA_WIDTH:0]     i_ppfifo_data,
  output logic                    o_axi_valid,
  input  logic                    i_axi_ready,
  output logic [DATA_WIDTH-1:0]   o_axi_data,
  output logic [STROBE_WIDTH-1:0] o_axi_keep,
  output logic                    o_axi_last
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, RELEASE} state_e;

  state_e                state_q, state_d;
  logic                  act_q, act_d;
  logic [23:0]           count_q, count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_end_q, rd_end_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;

  logic                  push, pop, push_last, stb;
  logic [2:0]            credit;

  // Skid buffer: entry 0 is the head presented on the AXI side.
  always_comb begin
    pop       = (occ_q != 2'd0) && i_axi_ready;
    push      = rd_pend_q;
    push_last = i_ppfifo_data[DATA_WIDTH] | (LAST_ON_BLOCK & rd_end_q);
    data0_d   = data0_q;
    data1_d   = data1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (push) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
        data0_d = i_ppfifo_data[DATA_WIDTH-1:0];
        last0_d = push_last;
      end else begin
        data1_d = i_ppfifo_data[DATA_WIDTH-1:0];
        last1_d = push_last;
      end
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  // A slot freed by this cycle's pop counts as credit, giving one word per clock.
  always_comb begin
    credit    = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    state_d   = state_q;
    act_d     = act_q;
    count_d   = count_q;
    stb       = 1'b0;
    rd_end_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ppfifo_rdy && !act_q) begin
          act_d   = 1'b1;
          count_d = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (count_q == i_ppfifo_size) begin
          state_d = DRAIN;
        end else if (credit < 3'd2) begin
          stb      = 1'b1;
          count_d  = count_q + 24'd1;
          rd_end_d = (count_q + 24'd1 == i_ppfifo_size);
        end
      end
      DRAIN: begin
        if (!rd_pend_q && (occ_d == 2'd0)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        act_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_pend_d = stb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_q     <= 1'b0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_end_q  <= 1'b0;
      occ_q     <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      rd_end_q  <= rd_end_d;
      occ_q     <= occ_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
    end
  end

  assign o_ppfifo_act = act_q;
  assign o_ppfifo_stb = stb;
  assign o_axi_valid  = (occ_q != 2'd0);
  assign o_axi_data   = data0_q;
  assign o_axi_last   = last0_q;
  assign o_axi_keep   = '1;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_adapter_ppfifo_wl_2_axi_stream.sv
// Directed bench: a PPFIFO block model feeds two adapters (LAST_ON_BLOCK 0 and 1)
// and a queue of expected beats is checked on every clock.
module tb_adapter_ppfifo_wl_2_axi_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ppfifo_rdy;
  logic [23:0] i_ppfifo_size;
  logic [32:0] i_ppfifo_data;
  logic        i_axi_ready;
  logic        o_ppfifo_act, o_ppfifo_stb, o_axi_valid, o_axi_last;
  logic [31:0] o_axi_data;
  logic [3:0]  o_axi_keep;
  logic        lob_act, lob_stb, lob_valid, lob_last;
  logic [31:0] lob_data;
  logic [3:0]  lob_keep;

  always #5 clk = ~clk;

  adapter_ppfifo_wl_2_axi_stream #(.DATA_WIDTH(32), .LAST_ON_BLOCK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb), .i_ppfifo_data(i_ppfifo_data),
    .o_axi_valid(o_axi_valid), .i_axi_ready(i_axi_ready), .o_axi_data(o_axi_data),
    .o_axi_keep(o_axi_keep), .o_axi_last(o_axi_last));

  adapter_ppfifo_wl_2_axi_stream #(.DATA_WIDTH(32), .LAST_ON_BLOCK(1'b1)) dut_lob (
    .clk(clk), .rst_n(rst_n), .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(lob_act),
    .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(lob_stb), .i_ppfifo_data(i_ppfifo_data),
    .o_axi_valid(lob_valid), .i_axi_ready(i_axi_ready), .o_axi_data(lob_data),
    .o_axi_keep(lob_keep), .o_axi_last(lob_last));

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] word_mem [0:15][0:7];
  int          blk_size [0:15];
  int          nblk = 0, next_blk = 0, cur = 0;
  bit          in_use = 0;
  int          ptr = 0, blk_issued = 0;
  bit          data_due = 0;
  int          issued_total = 0, beats_total = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_lob[$];
  int          cyc = 0;
  bit          ready_mode = 0;
  logic [3:0]  rpat = 4'b1001;
  bit          prev_stall = 0, prev_stall_lob = 0;
  logic [31:0] prev_data, prev_data_lob;
  logic        prev_last, prev_last_lob;

  int          t_beats, t_stbs, t_lasts, t_lob_beats, t_lob_lasts, t_lob_last_idx;
  int          first_beat_cyc, last_beat_cyc, act_fall_cyc, act_rises;
  logic [31:0] first_data, last_data;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reset_stats();
    t_beats = 0; t_stbs = 0; t_lasts = 0; t_lob_beats = 0; t_lob_lasts = 0;
    t_lob_last_idx = 0; first_beat_cyc = 0; last_beat_cyc = 0; act_fall_cyc = 0;
    act_rises = 0; first_data = '0; last_data = '0;
  endtask

  task automatic add_block(input int size, input logic [31:0] base, input int last_idx);
    blk_size[nblk] = size;
    for (int i = 0; i < 8; i++)
      word_mem[nblk][i] = {(i == last_idx), base + 32'(i)};
    nblk++;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    i_axi_ready  = ready_mode ? rpat[cyc % 4] : 1'b1;
    i_ppfifo_rdy = (next_blk < nblk);
    if (in_use) i_ppfifo_size = 24'(blk_size[cur]);
    else if (next_blk < nblk) i_ppfifo_size = 24'(blk_size[next_blk]);
    else i_ppfifo_size = '0;
    if (data_due) begin
      if (ptr < 8) i_ppfifo_data = word_mem[cur][ptr];
      ptr++;
      data_due = 0;
    end
  endtask

  task automatic checkOutput();
    logic [32:0] e;
    if (prev_stall) begin
      chk("stall_valid", o_axi_valid, 1);
      chk("stall_data", o_axi_data, prev_data);
      chk("stall_last", o_axi_last, prev_last);
    end
    if (prev_stall_lob) begin
      chk("lob_stall_valid", lob_valid, 1);
      chk("lob_stall_data", lob_data, prev_data_lob);
      chk("lob_stall_last", lob_last, prev_last_lob);
    end
    if (in_use && !o_ppfifo_act) begin
      in_use = 0;
      act_fall_cyc = cyc;
    end
    if (!in_use && o_ppfifo_act) begin
      chk("claim_has_block", next_blk < nblk, 1);
      cur = next_blk; next_blk++; in_use = 1; ptr = 0; blk_issued = 0; act_rises++;
      for (int i = 0; i < blk_size[cur]; i++) begin
        e = word_mem[cur][i];
        exp_q.push_back(e);
        exp_lob.push_back({e[32] | (i == blk_size[cur] - 1), e[31:0]});
      end
    end
    if (o_ppfifo_stb) begin
      chk("stb_in_block", in_use && (blk_issued < blk_size[cur]), 1);
      blk_issued++; issued_total++; t_stbs++; data_due = 1;
    end
    if (o_axi_valid && i_axi_ready) begin
      chk("beat_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", o_axi_data, e[31:0]);
        chk("beat_last", o_axi_last, e[32]);
      end
      if (t_beats == 0) begin first_beat_cyc = cyc; first_data = o_axi_data; end
      last_beat_cyc = cyc; last_data = o_axi_data;
      t_beats++; beats_total++;
      if (o_axi_last) t_lasts++;
    end
    if (lob_valid && i_axi_ready) begin
      chk("lob_beat_pending", exp_lob.size() != 0, 1);
      if (exp_lob.size() != 0) begin
        e = exp_lob.pop_front();
        chk("lob_beat_data", lob_data, e[31:0]);
        chk("lob_beat_last", lob_last, e[32]);
      end
      t_lob_beats++;
      if (lob_last) begin t_lob_lasts++; t_lob_last_idx = t_lob_beats; end
    end
    chk("outstanding_le2", (issued_total - beats_total) <= 2, 1);
    prev_stall = o_axi_valid && !i_axi_ready;
    prev_data = o_axi_data; prev_last = o_axi_last;
    prev_stall_lob = lob_valid && !i_axi_ready;
    prev_data_lob = lob_data; prev_last_lob = lob_last;
  endtask

  task automatic step();
    applyStimulus();
    #1;
    checkOutput();
  endtask

  function automatic bit all_done();
    return (next_blk == nblk) && !in_use && (exp_q.size() == 0) && (exp_lob.size() == 0);
  endfunction

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done"}, all_done(), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_act"}, o_ppfifo_act, 0);
    chk({name, "_stb"}, o_ppfifo_stb, 0);
    chk({name, "_valid"}, o_axi_valid, 0);
    chk({name, "_data"}, o_axi_data, 0);
    chk({name, "_last"}, o_axi_last, 0);
    chk({name, "_keep"}, o_axi_keep, 4'hF);
    chk({name, "_lob_act"}, lob_act, 0);
    chk({name, "_lob_stb"}, lob_stb, 0);
    chk({name, "_lob_valid"}, lob_valid, 0);
    chk({name, "_lob_data"}, lob_data, 0);
    chk({name, "_lob_keep"}, lob_keep, 4'hF);
  endtask

  initial begin
    int n;
    rst_n = 1'b1; i_ppfifo_rdy = 0; i_ppfifo_size = '0; i_ppfifo_data = '0; i_axi_ready = 1;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] test 1: size 4, sink always ready");
    reset_stats(); add_block(4, 32'hA0, 3); run_until_done(100, "t1");
    chk("t1_beats", t_beats, 4);
    chk("t1_stbs", t_stbs, 4);
    chk("t1_lasts", t_lasts, 1);
    chk("t1_lob_lasts", t_lob_lasts, 1);
    chk("t1_first", first_data, 32'hA0);
    chk("t1_final", last_data, 32'hA3);
    chk("t1_consecutive", last_beat_cyc - first_beat_cyc, 3);
    chk("t1_act_drop", act_fall_cyc - last_beat_cyc, 2);

    $display("[TB] test 2: ready toggles 1,0,0,1");
    reset_stats(); ready_mode = 1; add_block(4, 32'hA0, 3); run_until_done(200, "t2");
    ready_mode = 0;
    chk("t2_beats", t_beats, 4);
    chk("t2_stbs", t_stbs, 4);
    chk("t2_lasts", t_lasts, 1);

    $display("[TB] test 3: size 0");
    reset_stats(); add_block(0, 32'h0, -1); run_until_done(50, "t3");
    chk("t3_stbs", t_stbs, 0);
    chk("t3_beats", t_beats, 0);
    chk("t3_act_pulses", act_rises, 1);

    $display("[TB] test 4: last-on-block");
    reset_stats(); add_block(3, 32'h40, -1); run_until_done(100, "t4");
    chk("t4_lasts", t_lasts, 0);
    chk("t4_lob_lasts", t_lob_lasts, 1);
    chk("t4_lob_last_idx", t_lob_last_idx, 3);

    $display("[TB] test 5: back-to-back blocks");
    reset_stats(); add_block(2, 32'h50, 1); add_block(2, 32'h52, 1); run_until_done(150, "t5");
    chk("t5_beats", t_beats, 4);
    chk("t5_act_pulses", act_rises, 2);
    chk("t5_first", first_data, 32'h50);
    chk("t5_final", last_data, 32'h53);
    chk("t5_lasts", t_lasts, 2);

    $display("[TB] test 6: reset mid-block");
    reset_stats(); add_block(5, 32'hB0, 4);
    n = 0;
    while (t_beats < 2 && n < 50) begin step(); n++; end
    chk("t6_two_beats", t_beats, 2);
    rst_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    exp_q.delete(); exp_lob.delete();
    data_due = 0; issued_total = 0; beats_total = 0;
    prev_stall = 0; prev_stall_lob = 0;
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    reset_stats(); add_block(2, 32'hC0, 1); run_until_done(100, "t6");
    chk("t6_beats", t_beats, 2);
    chk("t6_first", first_data, 32'hC0);
    chk("t6_final", last_data, 32'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
